// File: rtl/mem_bus_master_if.sv
// -----------------------------------------------------------------------------
// mem_bus_master_if
// Groups the request/response handshake, the fill-sweep controls and the
// memory-side control lines of mem_bus_master into one bundle.
//   master modport : used by mem_bus_master (bus initiator)
//   slave  modport : used by whatever drives requests and observes the bus
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_rdata                              : read response
//   fill_start/fill_value/fill_busy/fill_done        : fill sweep
//   mem_addr/mem_re/mem_we                           : memory control lines
// The bidirectional memory data bus stays a plain inout port of the master so
// its tristate driver is resolved on an ordinary net.
// -----------------------------------------------------------------------------
interface mem_bus_master_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, fill_start, fill_value,
        output req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done,
               mem_addr, mem_re, mem_we
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, fill_start, fill_value,
        input  req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done,
               mem_addr, mem_re, mem_we
    );
endinterface

// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
// Sole initiator on the shared single-port memory bus. Accepts valid/ready
// read and write requests, turns them into registered bus cycles, returns
// read data with a one-cycle response pulse, and can sweep one value into
// every memory address.
// Ports:
//   clock    : system clock, all state changes on posedge
//   reset    : asynchronous, active-high
//   bus      : mem_bus_master_if.master (request, response, fill, mem control)
//   mem_data : memory data bus, driven only while mem_we=1, else high-Z
// Timing: a request accepted at edge k is held in a one-entry stage, put on
// the bus for the cycle after edge k+1, and (for reads) captured into
// rsp_rdata at edge k+2. A new request can be accepted every cycle.
// -----------------------------------------------------------------------------
module mem_bus_master #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic                clock,
    input  logic                reset,
    mem_bus_master_if.master    bus,
    inout  wire  [DW-1:0]       mem_data
);

    // ST_ACCESS means the stage holds an accepted request that goes on the
    // bus at the next edge; ST_FILL covers the whole sweep.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    state_t        state_r,       state_nxt_s;
    logic          acc_write_r,   acc_write_nxt_s;
    logic [AW-1:0] acc_addr_r,    acc_addr_nxt_s;
    logic [DW-1:0] acc_wdata_r,   acc_wdata_nxt_s;
    logic [AW-1:0] mem_addr_r,    mem_addr_nxt_s;
    logic          mem_we_r,      mem_we_nxt_s;
    logic          mem_re_r,      mem_re_nxt_s;
    logic [DW-1:0] mem_wdata_r,   mem_wdata_nxt_s;
    logic          rsp_valid_r,   rsp_valid_nxt_s;
    logic [DW-1:0] rsp_rdata_r,   rsp_rdata_nxt_s;
    logic          fill_busy_r,   fill_busy_nxt_s;
    logic          fill_done_r,   fill_done_nxt_s;
    logic [DW-1:0] fill_value_r,  fill_value_nxt_s;
    // One bit wider than the address: the MSB set means every address has
    // been written and the sweep must stop without wrapping.
    logic [AW:0]   fill_cnt_r,    fill_cnt_nxt_s;

    logic          req_ready_s;
    logic          accept_s;

    assign req_ready_s = (state_r != ST_FILL) & ~bus.fill_start & ~reset;
    assign accept_s    = bus.req_valid & req_ready_s;

    // Next-state and next-output logic for the access/fill controller.
    always_comb begin
        state_nxt_s      = state_r;
        acc_write_nxt_s  = acc_write_r;
        acc_addr_nxt_s   = acc_addr_r;
        acc_wdata_nxt_s  = acc_wdata_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_we_nxt_s     = 1'b0;
        mem_re_nxt_s     = 1'b0;
        mem_wdata_nxt_s  = mem_wdata_r;
        rsp_valid_nxt_s  = mem_re_r;
        rsp_rdata_nxt_s  = rsp_rdata_r;
        fill_busy_nxt_s  = 1'b0;
        fill_done_nxt_s  = 1'b0;
        fill_value_nxt_s = fill_value_r;
        fill_cnt_nxt_s   = fill_cnt_r;

        // Read data is on the bus during the read cycle; capture it at its end.
        if (mem_re_r) begin
            rsp_rdata_nxt_s = mem_data;
        end else begin
            rsp_rdata_nxt_s = rsp_rdata_r;
        end

        case (state_r)
            ST_IDLE, ST_ACCESS: begin
                // A staged request always reaches the bus, even when a fill
                // starts at this same edge.
                if (state_r == ST_ACCESS) begin
                    mem_addr_nxt_s = acc_addr_r;
                    mem_we_nxt_s   = acc_write_r;
                    mem_re_nxt_s   = ~acc_write_r;
                    if (acc_write_r) begin
                        mem_wdata_nxt_s = acc_wdata_r;
                    end else begin
                        mem_wdata_nxt_s = mem_wdata_r;
                    end
                end else begin
                    mem_addr_nxt_s = mem_addr_r;
                end

                if (bus.fill_start) begin
                    state_nxt_s      = ST_FILL;
                    fill_value_nxt_s = bus.fill_value;
                    fill_cnt_nxt_s   = {(AW+1){1'b0}};
                end else if (accept_s) begin
                    state_nxt_s     = ST_ACCESS;
                    acc_write_nxt_s = bus.req_write;
                    acc_addr_nxt_s  = bus.req_addr;
                    acc_wdata_nxt_s = bus.req_wdata;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (!fill_cnt_r[AW]) begin
                    mem_we_nxt_s    = 1'b1;
                    mem_addr_nxt_s  = fill_cnt_r[AW-1:0];
                    mem_wdata_nxt_s = fill_value_r;
                    fill_busy_nxt_s = 1'b1;
                    fill_cnt_nxt_s  = fill_cnt_r + {{AW{1'b0}}, 1'b1};
                end else begin
                    fill_done_nxt_s = 1'b1;
                    fill_cnt_nxt_s  = {(AW+1){1'b0}};
                    state_nxt_s     = ST_IDLE;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sweep or access at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            acc_write_r  <= 1'b0;
            acc_addr_r   <= {AW{1'b0}};
            acc_wdata_r  <= {DW{1'b0}};
            mem_addr_r   <= {AW{1'b0}};
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_wdata_r  <= {DW{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= {DW{1'b0}};
            fill_busy_r  <= 1'b0;
            fill_done_r  <= 1'b0;
            fill_value_r <= {DW{1'b0}};
            fill_cnt_r   <= {(AW+1){1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            acc_write_r  <= acc_write_nxt_s;
            acc_addr_r   <= acc_addr_nxt_s;
            acc_wdata_r  <= acc_wdata_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_re_r     <= mem_re_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            rsp_valid_r  <= rsp_valid_nxt_s;
            rsp_rdata_r  <= rsp_rdata_nxt_s;
            fill_busy_r  <= fill_busy_nxt_s;
            fill_done_r  <= fill_done_nxt_s;
            fill_value_r <= fill_value_nxt_s;
            fill_cnt_r   <= fill_cnt_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.fill_busy = fill_busy_r;
    assign bus.fill_done = fill_done_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_re    = mem_re_r;
    assign bus.mem_we    = mem_we_r;

    // The data bus is released whenever this block is not writing.
    assign mem_data = mem_we_r ? mem_wdata_r : {DW{1'bz}};

endmodule
